// File: rtl/cpu_run_ctrl.sv
// CPU run controller: per-button synchronize/debounce plus a mode FSM producing a CPU clock-enable.
// Define CPU_RUN_CTRL_TICK_COUNT_EN to build the cpu_en pulse counter on tick_count.

module cpu_run_deb #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1, r_s2;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      o_rise <= 1'b0;
      if (r_s2 == o_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // Input has differed for DEB_CYCLES samples: accept the new level.
        o_level <= r_s2;
        o_rise  <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module cpu_run_ctrl #(
  parameter int NBTN       = 2,
  parameter int DEB_CYCLES = 50000,
  parameter int DIV_W      = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBTN-1:0]  btn_raw,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] slow_div,
  output logic [NBTN-1:0]  btn_level,
  output logic [NBTN-1:0]  btn_rise,
  output logic             cpu_en,
  output logic [15:0]      tick_count
);
  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_SLOW = 2'b01,
    S_HALT = 2'b10,
    S_STEP = 2'b11
  } state_t;

  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    cpu_run_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_raw[g]),
      .o_level (btn_level[g]),
      .o_rise  (btn_rise[g])
    );
  end

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt, w_div_eff;
  logic             r_cpu_en, w_en_nxt, w_term;

  assign w_div_eff = (slow_div == '0) ? DIV_W'(1) : slow_div;
  // >= rather than == so a shrinking slow_div wraps immediately.
  assign w_term    = (r_div >= (w_div_eff - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_HALT;
      r_div    <= '0;
      r_cpu_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_cpu_en <= w_en_nxt;
    end
  end

  // Enable for the next cycle depends only on the state held this cycle;
  // the divider sits at 0 outside SLOW so every entry starts a fresh period.
  always_comb begin
    w_state_nxt = state_t'(mode);
    w_en_nxt    = 1'b0;
    w_div_nxt   = '0;
    case (r_state)
      S_RUN:  w_en_nxt = 1'b1;
      S_SLOW: begin
        w_en_nxt  = w_term;
        w_div_nxt = w_term ? '0 : r_div + DIV_W'(1);
      end
      S_STEP: w_en_nxt = btn_rise[0];
      default: w_en_nxt = 1'b0;
    endcase
  end

  assign cpu_en = r_cpu_en;

`ifdef CPU_RUN_CTRL_TICK_COUNT_EN
  logic [15:0] r_tick;

  always_ff @(posedge clk) begin
    if (rst) r_tick <= 16'h0000;
    else     r_tick <= r_tick + {15'd0, r_cpu_en};
  end

  assign tick_count = r_tick;
`else
  assign tick_count = 16'h0000;
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with DEB_CYCLES=4, DIV_W=8.
module tb_cpu_run_ctrl;
  localparam int NBTN = 2;
  localparam int DEB  = 4;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NBTN-1:0] btn_raw;
  logic [1:0]      mode;
  logic [DW-1:0]   slow_div;
  logic [NBTN-1:0] btn_level, btn_rise;
  logic            cpu_en;
  logic [15:0]     tick_count;

  int n_vec = 0;
  int n_err = 0;
  logic exp_a[$];
  logic exp_b[$];

  cpu_run_ctrl #(.NBTN(NBTN), .DEB_CYCLES(DEB), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .mode       (mode),
    .slow_div   (slow_div),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .cpu_en     (cpu_en),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_raw = '0; mode = 2'b10; slow_div = 8'd5;
    tick; tick;
    n_vec++;
    if (cpu_en !== 1'b0 || btn_level !== 2'b00 || btn_rise !== 2'b00 || tick_count !== 16'h0000) begin
      n_err++;
      $display("FAIL reset: got en=%b lvl=%b rise=%b tc=%h want 0 00 00 0000", cpu_en, btn_level, btn_rise, tick_count);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_debounce;
    logic ea, eb;
    // press on channel 1: level and rise exactly DEB+2 edges later
    btn_raw = 2'b10;
    for (int k = 1; k <= 8; k++) begin exp_a.push_back(k >= 6); exp_b.push_back(k == 6); end
    for (int k = 1; k <= 8; k++) begin
      tick; ea = exp_a.pop_front(); eb = exp_b.pop_front();
      n_vec++;
      if (btn_level[1] !== ea || btn_rise[1] !== eb) begin
        n_err++;
        $display("FAIL deb_press edge %0d: got lvl=%b rise=%b want lvl=%b rise=%b", k, btn_level[1], btn_rise[1], ea, eb);
      end
    end
    // release: level falls, no rise
    btn_raw = 2'b00;
    for (int k = 1; k <= 8; k++) begin exp_a.push_back(k < 6); exp_b.push_back(1'b0); end
    for (int k = 1; k <= 8; k++) begin
      tick; ea = exp_a.pop_front(); eb = exp_b.pop_front();
      n_vec++;
      if (btn_level[1] !== ea || btn_rise[1] !== eb) begin
        n_err++;
        $display("FAIL deb_release edge %0d: got lvl=%b rise=%b want lvl=%b rise=%b", k, btn_level[1], btn_rise[1], ea, eb);
      end
    end
    // 3-cycle glitch is swallowed
    btn_raw = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) btn_raw = 2'b00;
      tick;
      n_vec++;
      if (btn_level[1] !== 1'b0 || btn_rise[1] !== 1'b0) begin
        n_err++;
        $display("FAIL deb_glitch edge %0d: got lvl=%b rise=%b want 0 0", k, btn_level[1], btn_rise[1]);
      end
    end
  endtask

  task automatic test_slow;
    logic ea;
    slow_div = 8'd5; mode = 2'b01;
    // edge 1 enters SLOW; pulses every 5 cycles after entry
    for (int k = 1; k <= 21; k++) exp_a.push_back(k >= 6 && ((k - 1) % 5) == 0);
    for (int k = 1; k <= 21; k++) begin
      tick; ea = exp_a.pop_front();
      n_vec++;
      if (cpu_en !== ea) begin
        n_err++;
        $display("FAIL slow5 edge %0d: got en=%b want %b", k, cpu_en, ea);
      end
    end
    slow_div = 8'd0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      n_vec++;
      if (cpu_en !== 1'b1) begin
        n_err++;
        $display("FAIL slow0 edge %0d: got en=%b want 1", k, cpu_en);
      end
    end
    mode = 2'b10;
    exp_a.push_back(1'b1); exp_a.push_back(1'b0); exp_a.push_back(1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick; ea = exp_a.pop_front();
      n_vec++;
      if (cpu_en !== ea) begin
        n_err++;
        $display("FAIL slow_halt edge %0d: got en=%b want %b", k, cpu_en, ea);
      end
    end
  endtask

  task automatic test_step;
    logic ea;
    rst = 1'b1; tick; rst = 1'b0;
    mode = 2'b11; tick; tick;
    for (int p = 0; p < 3; p++) begin
      btn_raw = 2'b01;
      // rise at edge 6, enable the cycle after
      for (int k = 1; k <= 16; k++) exp_a.push_back(k == 7);
      for (int k = 1; k <= 16; k++) begin
        if (k == 9) btn_raw = 2'b00;
        tick; ea = exp_a.pop_front();
        n_vec++;
        if (cpu_en !== ea) begin
          n_err++;
          $display("FAIL step press %0d edge %0d: got en=%b want %b", p, k, cpu_en, ea);
        end
      end
    end
    n_vec++;
`ifdef CPU_RUN_CTRL_TICK_COUNT_EN
    if (tick_count !== 16'd3) begin
      n_err++;
      $display("FAIL step_count: got %0d want 3", tick_count);
    end
`else
    if (tick_count !== 16'd0) begin
      n_err++;
      $display("FAIL step_count: got %0d want 0", tick_count);
    end
`endif
  endtask

  task automatic test_mode_race;
    btn_raw = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      if (k == 6) mode = 2'b10;
      tick;
      n_vec++;
      if (cpu_en !== 1'b0) begin
        n_err++;
        $display("FAIL race edge %0d: got en=%b want 0", k, cpu_en);
      end
      if (k == 6) begin
        n_vec++;
        if (btn_rise[0] !== 1'b1) begin
          n_err++;
          $display("FAIL race_rise: got rise0=%b want 1", btn_rise[0]);
        end
      end
    end
    btn_raw = 2'b00;
    for (int k = 0; k < 8; k++) tick;
  endtask

  task automatic test_reset_mid;
    logic ea;
    mode = 2'b01; slow_div = 8'd3; btn_raw = 2'b01;
    tick; tick; tick;
    // this edge would have carried the first SLOW pulse
    rst = 1'b1; tick;
    n_vec++;
    if (cpu_en !== 1'b0 || btn_level !== 2'b00 || btn_rise !== 2'b00 || tick_count !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_mid: got en=%b lvl=%b rise=%b tc=%h want 0 00 00 0000", cpu_en, btn_level, btn_rise, tick_count);
    end
    rst = 1'b0; mode = 2'b00;
    for (int k = 1; k <= 5; k++) exp_a.push_back(k >= 2);
    for (int k = 1; k <= 5; k++) begin
      tick; ea = exp_a.pop_front();
      n_vec++;
      if (cpu_en !== ea || btn_rise[0] !== 1'b0 || btn_level[0] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_release edge %0d: got en=%b rise0=%b lvl0=%b want en=%b rise0=0 lvl0=0", k, cpu_en, btn_rise[0], btn_level[0], ea);
      end
    end
    btn_raw = 2'b00;
  endtask

  task automatic test_tick_wrap;
    logic [15:0] e;
    rst = 1'b1; tick; rst = 1'b0; mode = 2'b00;
    for (int n = 1; n <= 65539; n++) begin
      tick;
      if (n == 10 || n == 65537 || n == 65539) begin
`ifdef CPU_RUN_CTRL_TICK_COUNT_EN
        e = 16'(n - 2);
`else
        e = 16'h0000;
`endif
        n_vec++;
        if (tick_count !== e || cpu_en !== 1'b1) begin
          n_err++;
          $display("FAIL tick_wrap edge %0d: got tc=%h en=%b want tc=%h en=1", n, tick_count, cpu_en, e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; btn_raw = '0; mode = 2'b10; slow_div = '0;
    test_reset;
    test_debounce;
    test_slow;
    test_step;
    test_mode_race;
    test_reset_mid;
    test_tick_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
